// File: rtl/opkey_pulse_pkg.sv
// Shared constants for the operator-key front end: key indices and the
// default debounce settings used by both the top level and the bench.
package opkey_pulse_pkg;

   localparam int NUM_KEYS       = 3;
   localparam int KEY_RUN        = 0;
   localparam int KEY_STEP_INST  = 1;
   localparam int KEY_STEP_PHASE = 2;

   localparam int DB_COUNT_DEFAULT = 20000;
   localparam int DB_WIDTH_DEFAULT = 16;

endpackage : opkey_pulse_pkg

// File: rtl/opkey_pulse_if.sv
// Operator-key bundle: raw active-low buttons in, request pulses and LED levels out.
// Pulses are single-cycle strobes with no ready/backpressure: the phase generator
// must act on run/step_inst/step_phase in the cycle they are high, at most one at a time.
interface opkey_pulse_if;
   logic       key_run_n;
   logic       key_step_inst_n;
   logic       key_step_phase_n;
   logic       run;
   logic       step_inst;
   logic       step_phase;
   logic [2:0] key_level;

   modport master (
      output key_run_n, key_step_inst_n, key_step_phase_n,
      input  run, step_inst, step_phase, key_level
   );

   modport slave (
      input  key_run_n, key_step_inst_n, key_step_phase_n,
      output run, step_inst, step_phase, key_level
   );
endinterface : opkey_pulse_if

// File: rtl/opkey_pulse_key_debounce.sv
// One key: two-flop synchroniser, debounce counter and debounced level.
// press is a combinational strobe, high in the cycle before stable rises.
module key_debounce #(
   parameter int DB_COUNT = 20000,
   parameter int DB_WIDTH = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic key_n,
   output logic press,
   output logic level
);

   localparam logic [DB_WIDTH-1:0] CNT_MAX = DB_WIDTH'(DB_COUNT - 1);

   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic                stable_q, stable_d;
   logic [DB_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = ~key_n;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      press    = 1'b0;
      // Any cycle agreeing with stable restarts the count, so short glitches vanish.
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            press    = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level = stable_q;

endmodule : key_debounce

// File: rtl/opkey_pulse.sv
// Operator-key front end: three debounced keys feeding a fixed-priority
// arbiter (run > step_inst > step_phase) with registered one-hot pulses.
module opkey_pulse
   import opkey_pulse_pkg::*;
#(
   parameter int DB_COUNT = DB_COUNT_DEFAULT,
   parameter int DB_WIDTH = DB_WIDTH_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   opkey_pulse_if.slave bus
);

   logic [NUM_KEYS-1:0] press;
   logic [NUM_KEYS-1:0] level;
   logic [NUM_KEYS-1:0] key_n;
   logic [NUM_KEYS-1:0] pulse_q, pulse_d;

   assign key_n[KEY_RUN]        = bus.key_run_n;
   assign key_n[KEY_STEP_INST]  = bus.key_step_inst_n;
   assign key_n[KEY_STEP_PHASE] = bus.key_step_phase_n;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
         .DB_COUNT (DB_COUNT),
         .DB_WIDTH (DB_WIDTH)
      ) u_key_debounce (
         .clock (clock),
         .reset (reset),
         .key_n (key_n[k]),
         .press (press[k]),
         .level (level[k])
      );
   end

   // Losing presses are dropped: their stable level still updates inside the debouncer.
   always_comb begin
      pulse_d = '0;
      if (press[KEY_RUN]) begin
         pulse_d[KEY_RUN] = 1'b1;
      end else if (press[KEY_STEP_INST]) begin
         pulse_d[KEY_STEP_INST] = 1'b1;
      end else if (press[KEY_STEP_PHASE]) begin
         pulse_d[KEY_STEP_PHASE] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pulse_q <= '0;
      end else begin
         pulse_q <= pulse_d;
      end
   end

   assign bus.run        = pulse_q[KEY_RUN];
   assign bus.step_inst  = pulse_q[KEY_STEP_INST];
   assign bus.step_phase = pulse_q[KEY_STEP_PHASE];
   assign bus.key_level  = level;

endmodule : opkey_pulse

// File: doc/opkey_pulse.md
# opkey_pulse

Operator-key front end for the phase generator. Takes the three raw, bouncing, asynchronous push-button inputs (RUN, STEP_INST, STEP_PHASE) and produces the clean single-cycle `run`, `step_inst` and `step_phase` request pulses that the phase generator consumes directly. Each key is synchronised, debounced and edge-detected. At most one request pulse is issued per clock.

## Interface
- `DB_COUNT`, default 20000: consecutive stable cycles required to accept a level change. Legal range is 2 to 2^`DB_WIDTH`-1.
- `DB_WIDTH`, default 16: debounce counter width.
- `clock`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: one clock; reset is asynchronous and active-low (`reset` = 0 resets).
- `key_run_n`, input, 1: raw RUN button, asynchronous, active-low (0 = pressed).
- `key_step_inst_n`, input, 1: raw STEP_INST button, asynchronous, active-low.
- `key_step_phase_n`, input, 1: raw STEP_PHASE button, asynchronous, active-low.
- `run`, output, 1: one-cycle pulse on a debounced RUN press. Drives phase generator `run`.
- `step_inst`, output, 1: one-cycle pulse on a debounced STEP_INST press.
- `step_phase`, output, 1: one-cycle pulse on a debounced STEP_PHASE press.
- `key_level`, output, 3: debounced pressed levels, active-high, ordered {step_phase, step_inst, run}. Intended for LEDs.

## Operation
- **Per-key pipeline**
  - Two-flop synchroniser. The output is inverted so that 1 = pressed.
  - Debounce counter and debounced level register `stable`.
- **Debounce**
  - If the synchronised level equals `stable`, the counter clears to 0.
  - If it differs, the counter increments.
  - When the counter equals `DB_COUNT`-1 and the level still differs, `stable` takes the new level and the counter clears.
  - A mismatch shorter than `DB_COUNT` cycles is discarded with no effect.
- **Press event:** a `stable` transition 0->1. Releases (1->0) are debounced identically but generate no pulse.
- **Arbitration:** if several press events occur on the same edge, priority is run > step_inst > step_phase.
  - Only the winner pulses.
  - The losers' `stable` still updates, so their press is dropped, not queued. A new release and press is required.
- **Outputs:** `run`/`step_inst`/`step_phase` are registered and mutually exclusive (one-hot or zero every cycle).
- **Holding a key:** yields exactly one pulse. No auto-repeat.
- **Reset values:** synchronisers at released, `stable`=0, counters=0, all pulse outputs 0, `key_level`=3'b000.
- **Key held through reset release:** treated as a new press, giving one pulse after the normal latency.
- **Counter width:** the counter never exceeds `DB_COUNT`-1. No wrap-around is possible with a legal `DB_COUNT`.

## Timing
- **Press latency:** raw input low and clean from before rising edge 1.
  - Synchroniser output valid after edge 2.
  - `stable`=1 and the pulse register set after edge `DB_COUNT`+2.
  - Pulse high for exactly the one cycle between edges `DB_COUNT`+2 and `DB_COUNT`+3.
- **`key_level`:** changes on the same edge as `stable`.
- **Release latency:** also `DB_COUNT`+2 edges to `key_level`=0.
- **Minimum re-press interval:** a release must be stable for `DB_COUNT` cycles before the next press can be accepted.
- **Reset assertion:** takes effect immediately and asynchronously. Any pulse in flight is cancelled and counting restarts from 0 after deassertion.

## Structure
- Shared header/package holds:
  - key index constants: `KEY_RUN`=0, `KEY_STEP_INST`=1, `KEY_STEP_PHASE`=2;
  - default `DB_COUNT`/`DB_WIDTH`, so the top level and testbench use the same values.
- One sub-module, `key_debounce`, instantiated 3 times.
  - Contents: synchroniser, counter, `stable` register, and a one-cycle `press` strobe.
  - Parameters: `DB_COUNT`, `DB_WIDTH`.
- The `opkey_pulse` top contains the priority arbiter and output registers.
- Expected size: about 150–200 lines of RTL in total.

## Test plan
All tests use `DB_COUNT`=4.
- **Clean press:** `key_run_n` driven low and held 20 cycles.
  - `run`=1 for exactly one cycle, 6 edges after the first low sample.
  - `key_level`=3'b001 from the same edge. No further pulse while held.
- **Bounce rejection:** `key_step_inst_n` toggles low 3 cycles, high 1, repeated 5 times, then held low.
  - No pulse during bouncing.
  - Exactly one `step_inst` pulse 6 edges after the final stable low begins.
- **Release debounce:** after a press, release with a 2-cycle glitch back to pressed, then release clean.
  - `key_level` falls 6 edges after the clean release. No pulse at any point.
- **Simultaneous press:** all three keys go low on the same cycle.
  - Only `run` pulses. `key_level`=3'b111.
  - Re-pressing `step_phase` alone after a full release produces a `step_phase` pulse.
- **Reset mid-count:** `reset`=0 asynchronously at counter value 2 while `key_step_phase_n` is held low.
  - All outputs 0 immediately.
  - After reset release, with the key still held, one `step_phase` pulse appears 6 edges later.
